// File: rtl/serial_parity_rx.sv
// serial_parity_rx: strobed serial receiver for start + DATA_W data + even parity + stop frames
module serial_parity_rx #(
  parameter int DATA_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rx_in,
  input  logic            bit_en,
  output logic [DATA_W:0] frame,
  output logic            frame_valid,
  output logic            parity_err,
  output logic            framing_err,
  output logic            busy
);
  localparam int CW = $clog2(DATA_W + 1);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  state_t            r_state;
  logic [CW-1:0]     r_cnt;
  logic [DATA_W-1:0] r_shift;
  logic              r_par;
  logic [DATA_W:0]   r_frame;
  logic              r_fv;
  logic              r_perr;
  logic              r_fe;
  // frame sequencing; the pulses clear every cycle and only the strobe advances the frame
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_frame <= '0;
      r_fv    <= 1'b0;
      r_perr  <= 1'b0;
      r_fe    <= 1'b0;
    end else begin
      r_fv <= 1'b0;
      r_fe <= 1'b0;
      if (bit_en) begin
        case (r_state)
          IDLE: if (!rx_in) begin
            r_state <= DATA;
            r_cnt   <= '0;
          end
          DATA: begin
            r_shift <= {rx_in, r_shift[DATA_W-1:1]};
            r_cnt   <= r_cnt + 1'b1;
            if (r_cnt == CW'(DATA_W - 1)) r_state <= PARITY;
          end
          PARITY: begin
            r_par   <= rx_in;
            r_state <= STOP;
          end
          STOP: begin
            r_state <= IDLE;
            if (rx_in) begin
              r_frame <= {r_par, r_shift};
              r_perr  <= ^{r_par, r_shift};
              r_fv    <= 1'b1;
            end else begin
              r_fe <= 1'b1;
            end
          end
        endcase
      end
    end
  end
  assign frame       = r_frame;
  assign frame_valid = r_fv;
  assign parity_err  = r_perr;
  assign framing_err = r_fe;
  assign busy        = (r_state != IDLE);
endmodule

// File: tb/tb_serial_parity_rx.sv
// tb_serial_parity_rx: randomized frame-level check of serial_parity_rx against a bit-list model
module tb_serial_parity_rx;
  localparam int W = 4;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         rx_in = 1'b1;
  logic         bit_en = 1'b0;
  logic [W:0]   frame;
  logic         frame_valid;
  logic         parity_err;
  logic         framing_err;
  logic         busy;
  int           checks = 0;
  int           errors = 0;
  logic [W:0]   exp_frame = '0;
  logic         exp_perr = 1'b0;
  logic         exp_fv = 1'b0;
  logic         exp_fe = 1'b0;

  serial_parity_rx #(.DATA_W(W)) dut (
    .clk(clk), .rst(rst), .rx_in(rx_in), .bit_en(bit_en),
    .frame(frame), .frame_valid(frame_valid), .parity_err(parity_err),
    .framing_err(framing_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick(input logic r, input logic e, input logic rs);
    @(negedge clk);
    rx_in = r;
    bit_en = e;
    rst = rs;
    @(posedge clk);
    #1;
    check("frame_valid", 32'(frame_valid), 32'(exp_fv));
    check("framing_err", 32'(framing_err), 32'(exp_fe));
    check("frame", 32'(frame), 32'(exp_frame));
    check("parity_err", 32'(parity_err), 32'(exp_perr));
  endtask

  task automatic send_frame(input logic [W-1:0] d, input logic p, input logic s, input int gap);
    logic bits [W+3];
    int   ones;
    bits[0] = 1'b0;
    for (int i = 0; i < W; i++) bits[i+1] = d[i];
    bits[W+1] = p;
    bits[W+2] = s;
    for (int k = 0; k < W + 3; k++) begin
      repeat (gap) tick(1'($urandom_range(1)), 1'b0, 1'b0);
      if (k == W + 2) begin
        exp_fv = s;
        exp_fe = !s;
        if (s) begin
          ones = 0;
          for (int i = 0; i <= W; i++) begin
            exp_frame[i] = bits[i+1];
            ones += int'(bits[i+1]);
          end
          exp_perr = 1'(ones % 2);
        end
      end
      tick(bits[k], 1'b1, 1'b0);
      exp_fv = 1'b0;
      exp_fe = 1'b0;
      if (k == 0) check("busy_start", 32'(busy), 32'd1);
      if (k == W + 2) check("busy_end", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    tick(1'b1, 1'b0, 1'b1);
    tick(1'b0, 1'b1, 1'b1);
    check("busy_reset", 32'(busy), 32'd0);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    check("busy_ignored_low", 32'(busy), 32'd0);
    tick(1'b1, 1'b0, 1'b0);
    send_frame(4'b1011, 1'b1, 1'b1, 0);
    check("good_frame", 32'(frame), 32'b11011);
    send_frame(4'b0101, 1'b1, 1'b1, 1);
    check("perr_frame", 32'(frame), 32'b10101);
    check("perr_flag", 32'(parity_err), 32'd1);
    send_frame(4'b1011, 1'b1, 1'b1, 0);
    send_frame(4'b0110, 1'b0, 1'b0, 2);
    check("frame_kept", 32'(frame), 32'b11011);
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    check("busy_mid", 32'(busy), 32'd1);
    exp_frame = '0;
    exp_perr = 1'b0;
    tick(1'b1, 1'b1, 1'b1);
    check("busy_after_rst", 32'(busy), 32'd0);
    send_frame(4'b1011, 1'b1, 1'b1, 0);
    send_frame(4'(($urandom)), 1'($urandom_range(1)), 1'b1, 3);
    send_frame(4'(($urandom)), 1'($urandom_range(1)), 1'b1, 0);
    send_frame(4'(($urandom)), 1'($urandom_range(1)), 1'b1, 3);
    for (int c = 0; c < 32; c++)
      send_frame(c[W-1:0], c[W], 1'b1, int'($urandom_range(3)));
    for (int n = 0; n < 40; n++)
      send_frame(4'(($urandom)), 1'($urandom_range(1)), 1'($urandom_range(3) != 0), int'($urandom_range(4)));
    tick(1'b1, 1'b0, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_parity_rx.md
SERIAL_PARITY_RX -- requirements
Module: serial_parity_rx

Interface
REQ-001 SHALL have parameter: DATA_W, default 4, number of data bits per frame (frame word is DATA_W+1 bits: data plus even-parity bit).
REQ-002 SHALL have port: clk  input  1  single system clock; all state changes on rising edge.
REQ-003 SHALL have port: rst  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 SHALL have port: rx_in  input  1  serial line; idle level 1.
REQ-005 SHALL have port: bit_en  input  1  bit-rate strobe; rx_in sampled only on edges where bit_en=1.
REQ-006 SHALL have port: frame  output  DATA_W+1  last good-stop frame; frame[DATA_W-1:0]=data (first received bit in bit 0), frame[DATA_W]=received parity bit.
REQ-007 SHALL have port: frame_valid  output  1  one-cycle pulse: frame updated.
REQ-008 SHALL have port: parity_err  output  1  XOR of all DATA_W+1 bits of frame; valid while frame_valid=1, held until next update.
REQ-009 SHALL have port: framing_err  output  1  one-cycle pulse: stop bit sampled as 0.
REQ-010 SHALL have port: busy  output  1  high whenever state is not IDLE.

Function
REQ-011 SHALL implement a 4-state FSM: IDLE, DATA, PARITY, STOP.
REQ-012 IDLE: bit_en=1 and rx_in=0 SHALL go to DATA with bit counter cleared; rx_in=0 with bit_en=0 SHALL be ignored.
REQ-013 DATA: each bit_en=1 edge SHALL shift rx_in into data shift register LSB-first and increment counter; the DATA_W-th sample SHALL go to PARITY.
REQ-014 PARITY: bit_en=1 edge SHALL capture rx_in as parity bit and go to STOP.
REQ-015 STOP: bit_en=1 edge with rx_in=1 SHALL load frame, parity_err, set frame_valid=1 for the following cycle only, go to IDLE.
REQ-016 STOP: bit_en=1 edge with rx_in=0 SHALL pulse framing_err for one cycle, leave frame, parity_err, frame_valid unchanged/low, go to IDLE.
REQ-017 All edges with bit_en=0 SHALL hold state, counter, shift register; frame_valid and framing_err SHALL return to 0 after one cycle regardless of bit_en.
REQ-018 Latency: frame_valid SHALL be high in the cycle immediately after the clock edge sampling the stop bit; frame total = DATA_W+3 bit_en samples.
REQ-019 Back-to-back frames SHALL be accepted: a start bit on the first bit_en after STOP SHALL be detected from IDLE without loss.
REQ-020 parity_err SHALL be 0 for even count of ones across data+parity, 1 otherwise.
REQ-021 Bit counter SHALL be sized ceil(log2(DATA_W+1)) bits and SHALL never wrap within a frame.

Reset
REQ-022 rst=1 SHALL force state IDLE, counter 0, shift register 0, frame=0, frame_valid=0, parity_err=0, framing_err=0, busy=0 at the next rising edge.
REQ-023 rst SHALL take priority over bit_en and rx_in in every state, including mid-frame; partial frame SHALL be discarded with no pulse on frame_valid or framing_err.

Verification
REQ-024 Good frame: DATA_W=4, start 0, data bits 1,1,0,1, parity 1, stop 1 -> frame=5'b11011, parity_err=0, frame_valid one cycle after stop sample.
REQ-025 Parity error: data bits 1,0,1,0, parity 1, stop 1 -> frame=5'b10101, parity_err=1, frame_valid one cycle.
REQ-026 Framing error: good frame then frame with stop=0 -> framing_err one-cycle pulse, frame_valid stays 0, frame still 5'b11011.
REQ-027 Reset mid-frame: rst=1 after 2 data bits -> busy=0, all outputs 0 next cycle; subsequent good frame received correctly.
REQ-028 Strobe gaps and glitches: bit_en every 4th cycle, rx_in toggling between strobes, then back-to-back frames -> only strobe samples affect result; both frames produce correct frame_valid pulses.
REQ-029 Exhaustive: all 32 data+parity combinations for DATA_W=4 -> parity_err equals XOR of the 5 bits in every case.
